draw_line: RTL and testbench

- Rasterises one straight line segment into pixel write requests for the 160x120 display SRAM, using integer Bresenham stepping.
- A single start_line pulse launches one line. Afterwards the block emits one pixel coordinate per clock with wr_valid, until both endpoints and every pixel between them have been produced.
- It sits between the graphics command logic and the display-SRAM write port.

---
 rtl/gfx_pkg.sv | 26 ++
 rtl/draw_line.sv | 147 ++++++++++++++
 tb/tb_draw_line.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the display-SRAM pixel pipeline:
// screen geometry, coordinate widths and the line rasteriser state type.
package gfx_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int LEN_W    = 8;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Internal coordinates are wide enough that a line may run off-screen without wrapping.
    localparam int C_W = 10;
    localparam int E_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW
    } line_state_t;

    typedef logic [X_W-1:0]        pix_x_t;
    typedef logic [Y_W-1:0]        pix_y_t;
    typedef logic signed [C_W-1:0] coord_t;
    typedef logic signed [E_W-1:0] err_t;

endpackage

// File: rtl/draw_line.sv
// Bresenham line rasteriser: one start_line pulse produces one pixel per clock,
// with off-screen points clipped by holding wr_valid low.
module draw_line #(
    parameter int SCREEN_W = gfx_pkg::SCREEN_W,
    parameter int SCREEN_H = gfx_pkg::SCREEN_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [gfx_pkg::X_W-1:0]   start_x_pos,
    input  logic [gfx_pkg::Y_W-1:0]   start_y_pos,
    input  logic [gfx_pkg::LEN_W-1:0] x_length,
    input  logic [gfx_pkg::LEN_W-1:0] y_length,
    input  logic                      start_line,
    output logic                      wr_valid,
    output logic [gfx_pkg::X_W-1:0]   write_x_pos,
    output logic [gfx_pkg::Y_W-1:0]   write_y_pos,
    output logic                      running
);
    import gfx_pkg::*;

    localparam coord_t ONE_C   = coord_t'(1);
    localparam coord_t SCR_W_C = coord_t'(SCREEN_W);
    localparam coord_t SCR_H_C = coord_t'(SCREEN_H);

    line_state_t      state_q;
    coord_t           start_x_q, start_y_q;
    logic [LEN_W-1:0] x_len_q, y_len_q;
    err_t             dx_q, dy_q, err_q;
    logic             sx_neg_q, sy_neg_q;
    logic [LEN_W-1:0] rem_q;
    coord_t           cur_x_q, cur_y_q;
    logic             wr_valid_q, running_q;
    pix_x_t           write_x_q;
    pix_y_t           write_y_q;

    err_t             x_len_ext, y_len_ext, abs_x, abs_y;
    logic [LEN_W-1:0] rem_init;
    err_t             e2, err_d;
    logic             step_x, step_y;
    coord_t           cur_x_d, cur_y_d;

    function automatic logic on_screen(input coord_t x, input coord_t y);
        return !x[C_W-1] && (x < SCR_W_C) && !y[C_W-1] && (y < SCR_H_C);
    endfunction

    always_comb begin
        x_len_ext = {{(E_W-LEN_W){x_len_q[LEN_W-1]}}, x_len_q};
        y_len_ext = {{(E_W-LEN_W){y_len_q[LEN_W-1]}}, y_len_q};
        abs_x     = x_len_ext[E_W-1] ? -x_len_ext : x_len_ext;
        abs_y     = y_len_ext[E_W-1] ? -y_len_ext : y_len_ext;
        rem_init  = (abs_x > abs_y) ? abs_x[LEN_W-1:0] : abs_y[LEN_W-1:0];

        // Both step decisions use the pre-update error term.
        e2      = err_q <<< 1;
        step_x  = e2 > -dy_q;
        step_y  = e2 < dx_q;
        err_d   = err_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (step_x) begin
            err_d   = err_d - dy_q;
            cur_x_d = sx_neg_q ? cur_x_q - ONE_C : cur_x_q + ONE_C;
        end
        if (step_y) begin
            err_d   = err_d + dx_q;
            cur_y_d = sy_neg_q ? cur_y_q - ONE_C : cur_y_q + ONE_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            start_x_q  <= '0;
            start_y_q  <= '0;
            x_len_q    <= '0;
            y_len_q    <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            err_q      <= '0;
            sx_neg_q   <= 1'b0;
            sy_neg_q   <= 1'b0;
            rem_q      <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            wr_valid_q <= 1'b0;
            running_q  <= 1'b0;
            write_x_q  <= '0;
            write_y_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_valid_q <= 1'b0;
                    running_q  <= 1'b0;
                    if (start_line) begin
                        start_x_q <= coord_t'(start_x_pos);
                        start_y_q <= coord_t'(start_y_pos);
                        x_len_q   <= x_length;
                        y_len_q   <= y_length;
                        running_q <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    dx_q       <= abs_x;
                    dy_q       <= abs_y;
                    sx_neg_q   <= x_len_q[LEN_W-1];
                    sy_neg_q   <= y_len_q[LEN_W-1];
                    err_q      <= abs_x - abs_y;
                    rem_q      <= rem_init;
                    cur_x_q    <= start_x_q;
                    cur_y_q    <= start_y_q;
                    write_x_q  <= start_x_q[X_W-1:0];
                    write_y_q  <= start_y_q[Y_W-1:0];
                    wr_valid_q <= on_screen(start_x_q, start_y_q);
                    state_q    <= DRAW;
                end
                DRAW: begin
                    // The output registers always show the point of the current DRAW cycle.
                    if (rem_q == '0) begin
                        wr_valid_q <= 1'b0;
                        running_q  <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        rem_q      <= rem_q - 1'b1;
                        err_q      <= err_d;
                        cur_x_q    <= cur_x_d;
                        cur_y_q    <= cur_y_d;
                        write_x_q  <= cur_x_d[X_W-1:0];
                        write_y_q  <= cur_y_d[Y_W-1:0];
                        wr_valid_q <= on_screen(cur_x_d, cur_y_d);
                    end
                end
                default: begin
                    wr_valid_q <= 1'b0;
                    running_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign wr_valid    = wr_valid_q;
    assign write_x_pos = write_x_q;
    assign write_y_pos = write_y_q;
    assign running     = running_q;

endmodule

// File: tb/tb_draw_line.sv
// Self-checking bench for draw_line: a reference Bresenham model fills a
// scoreboard queue that is drained one entry per DRAW cycle.
module tb_draw_line;

    typedef struct {
        bit v;
        int x;
        int y;
    } pix_t;

    logic       clk;
    logic       rst;
    logic [7:0] startX;
    logic [6:0] startY;
    logic [7:0] xLen;
    logic [7:0] yLen;
    logic       startLine;
    logic       wrValid;
    logic [7:0] writeX;
    logic [6:0] writeY;
    logic       running;

    pix_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    draw_line dut (
        .clk        (clk),
        .rst        (rst),
        .start_x_pos(startX),
        .start_y_pos(startY),
        .x_length   (xLen),
        .y_length   (yLen),
        .start_line (startLine),
        .wr_valid   (wrValid),
        .write_x_pos(writeX),
        .write_y_pos(writeY),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: push every expected DRAW cycle, then run the line and drain the queue.
    task automatic runLine(input int sx0, input int sy0, input int lx, input int ly,
                           input int injectAt, output int nValid, output int lastX,
                           output int lastY, output int xUp, output int yUp, output int yDown);
        pix_t p;
        int   x, y, dx, dy, stx, sty, err, e2, n, idx, prevX, prevY;
        bit   seen;
        x   = sx0;
        y   = sy0;
        dx  = (lx < 0) ? -lx : lx;
        dy  = (ly < 0) ? -ly : ly;
        stx = (lx < 0) ? -1 : 1;
        sty = (ly < 0) ? -1 : 1;
        err = dx - dy;
        n   = ((dx > dy) ? dx : dy) + 1;
        for (int i = 0; i < n; i++) begin
            p.v = (x >= 0) && (x < 160) && (y >= 0) && (y < 120);
            p.x = x;
            p.y = y;
            expQ.push_back(p);
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += stx; end
            if (e2 < dx)  begin err += dx; y += sty; end
        end

        startX    = 8'(sx0);
        startY    = 7'(sy0);
        xLen      = 8'(lx);
        yLen      = 8'(ly);
        startLine = 1'b1;
        @(negedge clk);
        startLine = 1'b0;
        checkCount++;
        if (running !== 1'b1 || wrValid !== 1'b0) begin
            $display("[TB] FAIL setup_cycle: running=%b wr_valid=%b, required running=1 wr_valid=0",
                     running, wrValid);
        end else passCount++;
        @(negedge clk);

        nValid = 0; lastX = -1; lastY = -1; xUp = 0; yUp = 0; yDown = 0;
        prevX = 0; prevY = 0; seen = 0; idx = 0;
        while (expQ.size() > 0) begin
            p = expQ.pop_front();
            checkCount++;
            if (wrValid !== p.v || running !== 1'b1) begin
                $display("[TB] FAIL draw_valid[%0d]: wr_valid=%b running=%b, required wr_valid=%b running=1",
                         idx, wrValid, running, p.v);
            end else passCount++;
            if (p.v) begin
                checkCount++;
                if (writeX !== 8'(p.x) || writeY !== 7'(p.y)) begin
                    $display("[TB] FAIL draw_pixel[%0d]: got (%0d,%0d), required (%0d,%0d)",
                             idx, writeX, writeY, p.x, p.y);
                end else passCount++;
            end
            if (wrValid === 1'b1) begin
                if (seen) begin
                    if (int'(writeX) > prevX) xUp++;
                    if (int'(writeY) > prevY) yUp++;
                    if (int'(writeY) < prevY) yDown++;
                end
                seen  = 1;
                prevX = int'(writeX);
                prevY = int'(writeY);
                nValid++;
                lastX = prevX;
                lastY = prevY;
            end
            if (idx == injectAt) begin
                startX    = 8'd1;
                startY    = 7'd1;
                xLen      = 8'd3;
                yLen      = 8'd3;
                startLine = 1'b1;
            end else begin
                startLine = 1'b0;
            end
            @(negedge clk);
            idx++;
        end
        startLine = 1'b0;
        checkCount++;
        if (running !== 1'b0 || wrValid !== 1'b0) begin
            $display("[TB] FAIL line_end: running=%b wr_valid=%b, required both 0", running, wrValid);
        end else passCount++;
    endtask

    task automatic checkSummary(input string name, input int nValid, input int lastX, input int lastY,
                                input int expN, input int expX, input int expY);
        checkCount++;
        if (nValid != expN || lastX != expX || lastY != expY) begin
            $display("[TB] FAIL %s_summary: %0d writes ending (%0d,%0d), required %0d ending (%0d,%0d)",
                     name, nValid, lastX, lastY, expN, expX, expY);
        end else passCount++;
    endtask

    task automatic test_reset();
        rst = 1'b1; startLine = 1'b0; startX = '0; startY = '0; xLen = '0; yLen = '0;
        @(negedge clk);
        @(negedge clk);
        checkCount++;
        if (wrValid !== 1'b0 || running !== 1'b0 || writeX !== 8'd0 || writeY !== 7'd0) begin
            $display("[TB] FAIL reset_state: wr_valid=%b running=%b pos=(%0d,%0d), required all 0",
                     wrValid, running, writeX, writeY);
        end else passCount++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_diagonal();
        int n, lx, ly, xu, yu, yd;
        runLine(28, 7, 20, 17, -1, n, lx, ly, xu, yu, yd);
        checkSummary("diagonal", n, lx, ly, 21, 48, 24);
        checkCount++;
        if (xu != 20 || yu != 17 || yd != 0) begin
            $display("[TB] FAIL diagonal_steps: xUp=%0d yUp=%0d yDown=%0d, required 20/17/0", xu, yu, yd);
        end else passCount++;
    endtask

    task automatic test_negative_y();
        int n, lx, ly, xu, yu, yd;
        runLine(12, 15, 10, -4, -1, n, lx, ly, xu, yu, yd);
        checkSummary("negative_y", n, lx, ly, 11, 22, 11);
        checkCount++;
        if (yu != 0 || yd != 4 || xu != 10) begin
            $display("[TB] FAIL negative_y_steps: xUp=%0d yUp=%0d yDown=%0d, required 10/0/4", xu, yu, yd);
        end else passCount++;
    endtask

    task automatic test_vertical_and_zero();
        int n, lx, ly, xu, yu, yd;
        @(negedge clk);
        runLine(40, 40, 0, 5, -1, n, lx, ly, xu, yu, yd);
        checkSummary("vertical", n, lx, ly, 6, 40, 45);
        @(negedge clk);
        runLine(40, 40, 0, 0, -1, n, lx, ly, xu, yu, yd);
        checkSummary("zero_len", n, lx, ly, 1, 40, 40);
    endtask

    task automatic test_clip();
        int n, lx, ly, xu, yu, yd;
        @(negedge clk);
        runLine(150, 0, 20, 0, -1, n, lx, ly, xu, yu, yd);
        checkSummary("clip", n, lx, ly, 10, 159, 0);
    endtask

    task automatic test_ignore_start();
        int n, lx, ly, xu, yu, yd;
        @(negedge clk);
        runLine(28, 7, 20, 17, 5, n, lx, ly, xu, yu, yd);
        checkSummary("ignore_start", n, lx, ly, 21, 48, 24);
    endtask

    task automatic test_reset_midline();
        startX = 8'd10; startY = 7'd10; xLen = 8'd100; yLen = 8'd50;
        startLine = 1'b1;
        @(negedge clk);
        startLine = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkCount++;
        if (wrValid !== 1'b1 || running !== 1'b1) begin
            $display("[TB] FAIL midline_active: wr_valid=%b running=%b, required both 1", wrValid, running);
        end else passCount++;
        rst = 1'b1;
        #1;
        checkCount++;
        if (wrValid !== 1'b0 || running !== 1'b0) begin
            $display("[TB] FAIL midline_reset: wr_valid=%b running=%b, required both 0", wrValid, running);
        end else passCount++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkCount++;
        if (wrValid !== 1'b0 || running !== 1'b0) begin
            $display("[TB] FAIL after_reset_idle: wr_valid=%b running=%b, required both 0", wrValid, running);
        end else passCount++;
    endtask

    task automatic test_back_to_back();
        int n, lx, ly, xu, yu, yd;
        runLine(5, 5, 3, 2, -1, n, lx, ly, xu, yu, yd);
        checkSummary("b2b_first", n, lx, ly, 4, 8, 7);
        runLine(100, 100, -3, -2, -1, n, lx, ly, xu, yu, yd);
        checkSummary("b2b_second", n, lx, ly, 4, 97, 98);
    endtask

    initial begin
        test_reset();
        test_diagonal();
        test_negative_y();
        test_vertical_and_zero();
        test_clip();
        test_ignore_start();
        test_reset_midline();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
